serial_chunk_adder: RTL
=======================

# serial_chunk_adder

Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands CHUNK bits per clock through a single CHUNK-bit adder slice, carrying between slices in a register. It is the general-width successor of the team's fixed 16-bit two-pass adder. It adds a start/busy/done handshake, a subtract mode, a signed-overflow flag, a held result and asynchronous reset. It sits in datapaths where adder area matters more than latency.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- Derived: NCHUNK = WIDTH/CHUNK. An elaboration-time error is raised if WIDTH % CHUNK != 0.

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled on a rising clock edge
- sub  in  1  0 = in1+in2, 1 = in1−in2; sampled with start
- in1  in  WIDTH  operand A; sampled with start
- in2  in  WIDTH  operand B; sampled with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; result/overflow valid
- result  out  WIDTH+1  {carry_out, sum}
- overflow  out  1  two's-complement overflow of the WIDTH-bit sum

## Operation
- Reset is asynchronous: state=IDLE, busy=0, done=0, result=0, overflow=0. All internal operand, carry, accumulator and index registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE: on start=1:
  - latch a=in1 and b=(sub ? ~in2 : in2);
  - set carry=sub and idx=0;
  - go to RUN.
- RUN: each cycle:
  - compute {c, s} = a[idx*CHUNK +: CHUNK] + b[idx*CHUNK +: CHUNK] + carry;
  - write s into acc[idx*CHUNK +: CHUNK], set carry=c, idx=idx+1.
  - After the chunk with idx = NCHUNK−1, go to DONE.
  - start is ignored in RUN.
- DONE (one cycle):
  - done=1;
  - result = {carry, acc};
  - overflow = (a[WIDTH−1] == b[WIDTH−1]) && (acc[WIDTH−1] != a[WIDTH−1]).
  - If start=1 in this cycle, a new operation is accepted as in IDLE and the next state is RUN. Otherwise the next state is IDLE.
- result and overflow are registered. They are updated only on entry to DONE and hold their value until the next DONE or reset. Partial sums are never visible on result.
- Subtract: result[WIDTH] is the inverted borrow, so 1 means in1 ≥ in2 unsigned.
- Operand changes after the start sample have no effect on the operation.

## Timing
- start sampled at edge T: busy=1 from T through T+NCHUNK.
- done=1 and result valid in the cycle after edge T+NCHUNK. Latency start→done is NCHUNK+1 clocks.
  - Defaults (NCHUNK=2): 3 clocks.
  - WIDTH=32, CHUNK=4: 9 clocks.
- busy is low in DONE and IDLE.
- Back-to-back: start asserted during done yields the next done NCHUNK+1 clocks later. No idle cycle is required.
- done never asserts for two consecutive cycles.
- Reset asserted mid-RUN: outputs clear immediately without a clock. After deassertion, no done is produced for the aborted operation.
- CHUNK = WIDTH: RUN lasts one cycle (latency 2).

## Test plan
- Default params, in1=0x00FF, in2=0x0001, sub=0, start 1 cycle → busy for 2 cycles, then done for 1 cycle, result=0x00100, overflow=0. Covers the inter-chunk carry.
- in1=0xFFFF, in2=0xFFFF, sub=0 → result=0x1FFFE, overflow=0. Then in1=0x7FFF, in2=0x0001 → result=0x08000, overflow=1.
- sub=1, in1=0x0005, in2=0x0007 → result=0x0FFFE (bit16=0, borrow). Then in1=0x8000, in2=0x0001 → result=0x17FFF, overflow=1.
- Start pulses while busy=1 are ignored, and in1 is changed mid-RUN: exactly one done with the originally sampled sum. Start asserted in the done cycle: a second done exactly 3 clocks later with the new operands' result.
- Assert reset one cycle after start, asynchronously between edges → busy, done, result and overflow read 0 before the next edge. No done follows. A fresh operation afterwards completes normally.
- WIDTH=32, CHUNK=4: in1=0x0FFFFFFF, in2=0x00000001, sub=0 → done exactly 9 clocks after start, result=0x010000000. Also check a WIDTH=12, CHUNK=5 build fails elaboration.

Source files
------------

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder
//   Multi-cycle adder/subtractor. A WIDTH-bit add (or subtract) is performed
//   CHUNK bits per clock through one CHUNK-bit adder slice, with the carry
//   held in a register between slices. A start/busy/done handshake frames
//   each operation. The result and the signed-overflow flag are registered
//   and hold their value until the next completed operation.
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       asynchronous, active-high reset
//   start_i     request, sampled in IDLE or in the DONE cycle
//   sub_i       0: in1+in2, 1: in1-in2 (sampled with start_i)
//   in1_i       operand A (sampled with start_i)
//   in2_i       operand B (sampled with start_i)
//   busy_o      high while chunks are being processed
//   done_o      one-cycle pulse, result_o/overflow_o valid
//   result_o    {carry_out, sum}; for subtract bit WIDTH is the inverted borrow
//   overflow_o  two's-complement overflow of the WIDTH-bit sum
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH:0]   result_o,
    output logic             overflow_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    // Reject parameter sets that do not split into whole chunks.
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH:0]    result_q, result_d;
    logic              overflow_q, overflow_d;

    logic [CHUNK-1:0]  a_chunk_s;
    logic [CHUNK-1:0]  b_chunk_s;
    logic [CHUNK:0]    sum_s;

    // The single shared adder slice, fed by the chunk selected by idx_q.
    always_comb begin
        a_chunk_s = a_q[int'(idx_q) * CHUNK +: CHUNK];
        b_chunk_s = b_q[int'(idx_q) * CHUNK +: CHUNK];
        sum_s     = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_q};
    end

    // Next-state and datapath control; every register holds unless changed.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    // Subtract is A + ~B + 1: the +1 enters as the initial carry.
                    a_d     = in1_i;
                    b_d     = sub_i ? ~in2_i : in2_i;
                    carry_d = sub_i;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d[int'(idx_q) * CHUNK +: CHUNK] = sum_s[CHUNK-1:0];
                carry_d = sum_s[CHUNK];
                if (idx_q == LAST_IDX) begin
                    idx_d      = '0;
                    state_d    = DONE;
                    result_d   = {sum_s[CHUNK], acc_d};
                    // Same-sign operands giving a different-sign sum.
                    overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign overflow_o = overflow_q;

endmodule
